regfile_scoreboard: RTL and testbench

- Parametrised general-purpose register file: DEPTH registers of WIDTH bits, two combinational read ports, one synchronous write port.
- Per-register busy scoreboard so decode can stall on registers owed by long-latency units (multdiv), instead of relying on external hazard bookkeeping.
- Successor to the fixed 32-bit single register: generalised in width and depth, with address decode and a hardwired-zero register 0.
- Sits between decode (reads, marks) and writeback (writes, clears).

---
 rtl/regfile_scoreboard_if.sv | 30 +++
 rtl/regfile_scoreboard.sv | 100 ++++++++++
 tb/tb_regfile_scoreboard.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard: write port, busy-mark port and two read ports.
// Master is decode/writeback, slave is the register file.
interface regfile_scoreboard_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              mark_en;
  logic [ADDR_W-1:0] mark_addr;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_a;
  logic [WIDTH-1:0]  rd_data_b;
  logic              rd_busy_a;
  logic              rd_busy_b;
  logic              any_busy;
  logic [ADDR_W:0]   busy_count;

  modport master (
    output we, wr_addr, wr_data, mark_en, mark_addr, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, any_busy, busy_count
  );

  modport slave (
    input  we, wr_addr, wr_data, mark_en, mark_addr, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, any_busy, busy_count
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// DEPTH x WIDTH register file (r0 hardwired to zero) with a per-register busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_WRITE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  rf
);
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             wr_hit_s;
  logic             mark_hit_s;

  function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
    logic [ADDR_W:0] n;
    n = {(ADDR_W+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      n = n + {{ADDR_W{1'b0}}, v[i]};
    end
    return n;
  endfunction

  assign wr_hit_s   = rf.we && (rf.wr_addr != {ADDR_W{1'b0}});
  assign mark_hit_s = rf.mark_en && (rf.mark_addr != {ADDR_W{1'b0}});

  // Next state: the write clears busy first so a same-address mark overrides it.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_hit_s) begin
      regs_d[rf.wr_addr] = rf.wr_data;
      busy_d[rf.wr_addr] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (mark_hit_s) begin
      busy_d[rf.mark_addr] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    regs_d[0] = {WIDTH{1'b0}};
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '{default: {WIDTH{1'b0}}};
      busy_q <= {DEPTH{1'b0}};
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  logic byp_a_s;
  logic byp_b_s;
  logic keep_busy_s;
  assign byp_a_s     = wr_hit_s && (rf.rd_addr_a == rf.wr_addr);
  assign byp_b_s     = wr_hit_s && (rf.rd_addr_b == rf.wr_addr);
  assign keep_busy_s = rf.mark_en && (rf.mark_addr == rf.wr_addr);

  // Read ports with forwarding of the in-flight write.
  always_comb begin
    rf.rd_data_a = regs_q[rf.rd_addr_a];
    rf.rd_busy_a = busy_q[rf.rd_addr_a];
    rf.rd_data_b = regs_q[rf.rd_addr_b];
    rf.rd_busy_b = busy_q[rf.rd_addr_b];
    if (byp_a_s) begin
      rf.rd_data_a = rf.wr_data;
      rf.rd_busy_a = keep_busy_s ? busy_q[rf.rd_addr_a] : 1'b0;
    end else begin
      rf.rd_data_a = regs_q[rf.rd_addr_a];
    end
    if (byp_b_s) begin
      rf.rd_data_b = rf.wr_data;
      rf.rd_busy_b = keep_busy_s ? busy_q[rf.rd_addr_b] : 1'b0;
    end else begin
      rf.rd_data_b = regs_q[rf.rd_addr_b];
    end
  end
`else
  // Read ports return stored state only.
  always_comb begin
    rf.rd_data_a = regs_q[rf.rd_addr_a];
    rf.rd_busy_a = busy_q[rf.rd_addr_a];
    rf.rd_data_b = regs_q[rf.rd_addr_b];
    rf.rd_busy_b = busy_q[rf.rd_addr_b];
  end
`endif

  assign rf.busy_count = popcount(busy_q);
  assign rf.any_busy   = |busy_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed test-plan items plus
// randomized traffic checked against an array-based reference model.
module tb_regfile_scoreboard;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [WIDTH-1:0] m_regs [DEPTH];
  bit               m_busy [DEPTH];

  regfile_scoreboard_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  regfile_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit bypass_hit(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_WRITE_BYPASS_EN
    return bus.we && bus.wr_addr != 5'd0 && a == bus.wr_addr;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] exp_data(input logic [ADDR_W-1:0] a);
    if (bypass_hit(a)) return bus.wr_data;
    return (a == 5'd0) ? 32'd0 : m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
    if (bypass_hit(a) && !(bus.mark_en && bus.mark_addr == bus.wr_addr)) return 1'b0;
    return (a == 5'd0) ? 1'b0 : m_busy[a];
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int i = 1; i < DEPTH; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Spec rules for one rising edge: write clears busy, mark sets it (mark wins).
  task automatic model_edge();
    if (bus.we && bus.wr_addr != 5'd0) begin
      m_regs[bus.wr_addr] = bus.wr_data;
      m_busy[bus.wr_addr] = 1'b0;
    end
    if (bus.mark_en && bus.mark_addr != 5'd0) m_busy[bus.mark_addr] = 1'b1;
  endtask

  task automatic check_outputs();
    int n;
    n = exp_count();
    check_eq("rd_data_a", bus.rd_data_a, exp_data(bus.rd_addr_a));
    check_eq("rd_data_b", bus.rd_data_b, exp_data(bus.rd_addr_b));
    check_eq("rd_busy_a", bus.rd_busy_a, exp_busy(bus.rd_addr_a));
    check_eq("rd_busy_b", bus.rd_busy_b, exp_busy(bus.rd_addr_b));
    check_eq("busy_count", bus.busy_count, n);
    check_eq("any_busy", bus.any_busy, n != 0);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic me, input logic [4:0] ma,
                       input logic [4:0] ra, input logic [4:0] rb);
    bus.we = we;  bus.wr_addr = wa;  bus.wr_data = wd;
    bus.mark_en = me;  bus.mark_addr = ma;
    bus.rd_addr_a = ra;  bus.rd_addr_b = rb;
  endtask

  // Check outputs mid-cycle, then commit the edge to the model.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic peek(input logic [4:0] ra, input logic [4:0] rb);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra, rb);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    model_reset();
    #2;
    check_outputs();
    #10;
    reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(i), 5'(DEPTH - 1 - i));
      step();
    end

    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);  step();
    drive(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0);  step();
    peek(5'd5, 5'd0);
    check_eq("r5_read", bus.rd_data_a, 32'hDEADBEEF);
    check_eq("r0_read", bus.rd_data_b, 32'd0);

    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0);  step();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);  step();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);  step();
    peek(5'd7, 5'd0);
    check_eq("mark_count", bus.busy_count, 6'd2);
    check_eq("mark_any", bus.any_busy, 1'b1);
    check_eq("r7_busy", bus.rd_busy_a, 1'b1);
    check_eq("r0_busy", bus.rd_busy_b, 1'b0);
    drive(1'b1, 5'd7, 32'h55, 1'b0, 5'd0, 5'd0, 5'd0);  step();
    peek(5'd7, 5'd0);
    check_eq("clear_count", bus.busy_count, 6'd1);
    check_eq("r7_data", bus.rd_data_a, 32'h55);
    check_eq("r7_cleared", bus.rd_busy_a, 1'b0);

    drive(1'b1, 5'd3, 32'hA5, 1'b1, 5'd3, 5'd0, 5'd0);  step();
    peek(5'd3, 5'd3);
    check_eq("r3_mark_wins", bus.rd_busy_a, 1'b1);
    check_eq("r3_data", bus.rd_data_b, 32'hA5);
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 5'd0, 5'd0);  step();
    peek(5'd4, 5'd6);
    check_eq("r4_busy", bus.rd_busy_a, 1'b1);
    check_eq("r6_data", bus.rd_data_b, 32'h66);

    drive(1'b1, 5'd10, 32'h1111, 1'b0, 5'd0, 5'd0, 5'd0);  step();
    drive(1'b1, 5'd10, 32'h2222, 1'b0, 5'd0, 5'd10, 5'd10);
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check_eq("r10_same_cycle", bus.rd_data_a, 32'h2222);
`else
    check_eq("r10_same_cycle", bus.rd_data_a, 32'h1111);
`endif
    step();
    peek(5'd10, 5'd0);
    check_eq("r10_next_cycle", bus.rd_data_a, 32'h2222);

    drive(1'b1, 5'd13, 32'hFF, 1'b1, 5'd12, 5'd0, 5'd0);  step();
    peek(5'd13, 5'd12);
    check_eq("r13_before_rst", bus.rd_data_a, 32'hFF);
    check_eq("r12_before_rst", bus.rd_busy_b, 1'b1);
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("r13_async_rst", bus.rd_data_a, 32'd0);
    check_eq("count_async_rst", bus.busy_count, 6'd0);
    check_eq("any_async_rst", bus.any_busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 5'd13, 32'h01, 1'b0, 5'd0, 5'd0, 5'd0);  step();
    peek(5'd13, 5'd0);
    check_eq("r13_after_rst", bus.rd_data_a, 32'h01);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa;
      logic [4:0] ma;
      wa = 5'($urandom_range(0, DEPTH - 1));
      ma = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, DEPTH - 1));
      drive(1'($urandom_range(0, 1)), wa, $urandom, ($urandom_range(0, 9) < 3), ma,
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, DEPTH - 1)),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, DEPTH - 1)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
